vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Parametrised raster scan-out engine, successor to the fixed 640x480 top-level timing path.
//  Generates the pixel coordinates to request, plus the frame count, from programmable timing.
//  Accepts pixel data from an image source with a fixed pipeline latency.
//  Re-aligns sync and data-enable to that latency, then drives registered, blanked RGB and sync.
//  Sits between the pixel/image generators and the DAC/pin outputs.
// PARAMETERS
//  H_VISIBLE    640  active pixels per line
//  H_FRONT      16   horizontal front porch, pixels
//  H_SYNC       96   hsync pulse width, pixels
//  H_BACK       48   horizontal back porch, pixels
//  V_VISIBLE    480  active lines per frame
//  V_FRONT      10   vertical front porch, lines
//  V_SYNC       2    vsync pulse width, lines
//  V_BACK       33   vertical back porch, lines
//  HSYNC_POL    0    active level of hsync (0 = active-low)
//  VSYNC_POL    0    active level of vsync
//  COLOR_W      4    bits per colour channel
//  SRC_LATENCY  1    cycles from req_x/req_y to valid src_r/g/b; legal range 0..7
//  Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)
// PORTS
//  clk_25_175   in   1        pixel clock (name kept; frequency set by timing mode)
//  rst          in   1        asynchronous, active-low reset
//  req_x        out  XW       horizontal counter; the coordinate requested from the source
//  req_y        out  YW       vertical counter
//  req_valid    out  1        high when req_x < H_VISIBLE && req_y < V_VISIBLE
//  frame        out  32       completed-frame counter
//  frame_start  out  1        high for the single cycle in which req_x == 0 && req_y == 0
//  src_r/g/b    in   COLOR_W  source pixel, valid SRC_LATENCY cycles after its request
//  hsync,vsync  out  1        registered sync outputs
//  de           out  1        registered data-enable, aligned with r/g/b
//  r,g,b        out  COLOR_W  registered pixel outputs; 0 whenever de = 0
// BEHAVIOUR
//  Counters:
//   - Line order is visible, front porch, sync, back porch; frame order is the same for lines.
//   - h counts 0..H_TOTAL-1 and wraps to 0.
//   - v increments on h wrap and wraps to 0 after V_TOTAL-1.
//   - frame increments by 1 (mod 2^32) on the cycle both counters wrap together.
//  Raw sync windows:
//   - hsync is active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
//   - vsync uses the same window on v, in lines, with V_* parameters.
//   - vsync edges coincide with h wrap.
//  Alignment:
//   - raw hsync, raw vsync and req_valid pass through a SRC_LATENCY-deep shift register.
//   - They then pass one output register stage.
//   - r/g/b <= delayed_valid ? src : 0, in the same output register.
//   - Total latency from counter state to pins is SRC_LATENCY+1 cycles for all outputs.
//   - SRC_LATENCY = 0 means src is sampled in the same cycle as the request.
//  Reset (asserted asynchronously, mid-frame included):
//   - h, v and frame go to 0.
//   - All delay stages go to inactive.
//   - r/g/b/de go to 0.
//   - hsync = !HSYNC_POL and vsync = !VSYNC_POL.
//  After reset:
//   - The first cycle after release presents req (0,0) with frame_start = 1.
//   - The first de = 1 appears SRC_LATENCY+1 cycles later.
//  No back-pressure; the source must honour SRC_LATENCY exactly.
//  src values outside the visible window are ignored.
// CONFIGURATION
//  Macro VGA_SCANOUT_CRC_EN. When defined, adds two ports:
//   - crc        out  16  CRC-16-CCITT (poly 0x1021) of the displayed frame
//   - crc_valid  out  1   one-cycle pulse marking the final CRC value
//  CRC rules:
//   - Seed 0xFFFF at the first de = 1 pixel of each frame.
//   - Per de = 1 cycle, fold {r,g,b} in MSB first.
//   - crc_valid pulses for one cycle in the cycle after the last visible output pixel.
//   - crc holds its value until the next frame's final pulse.
//   - Reset clears crc to 0 and crc_valid to 0.
//  When the macro is not defined: no CRC ports and no CRC logic; all other behaviour is identical.
// TESTING
//  1. Defaults, SRC_LATENCY 1 -> hsync low 96 of every 800 cycles; vsync low 1600 of every 420000; de high 640 cycles/line for 480 lines.
//  2. Source returns req_x[3:0] with SRC_LATENCY 2 -> first de pixel r = 0, last r = 15, each line; no shifted or skipped pixel.
//  3. src held at all-ones -> r/g/b = 0 whenever de = 0; r/g/b = 'hF whenever de = 1.
//  4. Small mode 8/1/2/1 x 4/1/1/1, HSYNC_POL 1 -> hsync high 2 of every 12 cycles; frame increments every 84 cycles; frame_start period 84.
//  5. rst pulsed at h = 300, v = 200 -> outputs take reset values immediately; after release, req = (0,0) with frame_start = 1; frame = 0.
//  6. With VGA_SCANOUT_CRC_EN, constant colour 0x5A3 over two frames -> two crc_valid pulses, identical crc equal to the model; a 1-pixel change alters crc.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Request/source port bundle between vga_scanout (master) and the image source (slave).
interface vga_scanout_if #(
   parameter int XW      = 10,
   parameter int YW      = 10,
   parameter int COLOR_W = 4
);
   logic [XW-1:0]      req_x;
   logic [YW-1:0]      req_y;
   logic               req_valid;
   logic [31:0]        frame;
   logic               frame_start;
   logic [COLOR_W-1:0] src_r;
   logic [COLOR_W-1:0] src_g;
   logic [COLOR_W-1:0] src_b;

   modport master (
      output req_x, req_y, req_valid, frame, frame_start,
      input  src_r, src_g, src_b
   );

   modport slave (
      input  req_x, req_y, req_valid, frame, frame_start,
      output src_r, src_g, src_b
   );
endinterface

// File: rtl/vga_scanout.sv
// Programmable raster scan-out: counters, source-latency alignment, registered blanked RGB/sync.
// Define VGA_SCANOUT_CRC_EN to add crc/crc_valid, a CRC-16-CCITT of every displayed frame.
module vga_scanout #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0,
   parameter int COLOR_W     = 4,
   parameter int SRC_LATENCY = 1,
   parameter int XW          = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
   parameter int YW          = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
   input  logic               clk_25_175,
   input  logic               rst,
   vga_scanout_if.master      src_if,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
`ifdef VGA_SCANOUT_CRC_EN
   ,
   output logic [15:0]        crc,
   output logic               crc_valid
`endif
);
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;
`ifdef VGA_SCANOUT_CRC_EN
   localparam int PW = 5;
`else
   localparam int PW = 3;
`endif

   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic [31:0]   frame_cnt;
   logic [31:0]   h32, v32;
   logic          h_wrap, v_wrap;
   logic          raw_hs, raw_vs, raw_vis;
   logic [PW-1:0] raw_p, dly_p;

   // 32-bit views keep window compares safe when a window end equals 2**XW
   assign h32     = 32'(h);
   assign v32     = 32'(v);
   assign h_wrap  = (h32 == 32'(H_TOTAL - 1));
   assign v_wrap  = (v32 == 32'(V_TOTAL - 1));
   assign raw_hs  = (h32 >= 32'(HS_START)) && (h32 < 32'(HS_END));
   assign raw_vs  = (v32 >= 32'(VS_START)) && (v32 < 32'(VS_END));
   assign raw_vis = (h32 < 32'(H_VISIBLE)) && (v32 < 32'(V_VISIBLE));

   always_ff @(posedge clk_25_175 or negedge rst) begin
      if (!rst) begin
         h         <= '0;
         v         <= '0;
         frame_cnt <= '0;
      end else if (h_wrap) begin
         h <= '0;
         if (v_wrap) begin
            v         <= '0;
            frame_cnt <= frame_cnt + 32'd1;
         end else begin
            v <= v + YW'(1);
         end
      end else begin
         h <= h + XW'(1);
      end
   end

   assign src_if.req_x       = h;
   assign src_if.req_y       = v;
   assign src_if.req_valid   = raw_vis;
   assign src_if.frame       = frame_cnt;
   assign src_if.frame_start = (h32 == 32'd0) && (v32 == 32'd0);

`ifdef VGA_SCANOUT_CRC_EN
   assign raw_p = {raw_vis && (h32 == 32'(H_VISIBLE - 1)) && (v32 == 32'(V_VISIBLE - 1)),
                   raw_vis && (h32 == 32'd0) && (v32 == 32'd0),
                   raw_vis, raw_vs, raw_hs};
`else
   assign raw_p = {raw_vis, raw_vs, raw_hs};
`endif

   // Pipe bits are active-high flags so the reset value '0 means inactive
   generate
      if (SRC_LATENCY == 0) begin : g_nodly
         assign dly_p = raw_p;
      end else begin : g_dly
         logic [PW-1:0] sr [SRC_LATENCY];
         always_ff @(posedge clk_25_175 or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < SRC_LATENCY; i++) sr[i] <= '0;
            end else begin
               sr[0] <= raw_p;
               for (int i = 1; i < SRC_LATENCY; i++) sr[i] <= sr[i-1];
            end
         end
         assign dly_p = sr[SRC_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk_25_175 or negedge rst) begin
      if (!rst) begin
         hsync <= !HSYNC_POL;
         vsync <= !VSYNC_POL;
         de    <= 1'b0;
         r     <= '0;
         g     <= '0;
         b     <= '0;
      end else begin
         hsync <= dly_p[0] ? HSYNC_POL : !HSYNC_POL;
         vsync <= dly_p[1] ? VSYNC_POL : !VSYNC_POL;
         de    <= dly_p[2];
         r     <= dly_p[2] ? src_if.src_r : '0;
         g     <= dly_p[2] ? src_if.src_g : '0;
         b     <= dly_p[2] ? src_if.src_b : '0;
      end
   end

`ifdef VGA_SCANOUT_CRC_EN
   logic        de_first, de_last;
   logic [15:0] crc_acc, crc_nxt;

   function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [3*COLOR_W-1:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 3*COLOR_W-1; i >= 0; i--)
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   assign crc_nxt = crc_fold(de_first ? 16'hFFFF : crc_acc, {r, g, b});

   // Runs one stage behind the pins so it folds exactly what was displayed
   always_ff @(posedge clk_25_175 or negedge rst) begin
      if (!rst) begin
         de_first  <= 1'b0;
         de_last   <= 1'b0;
         crc_acc   <= '0;
         crc       <= '0;
         crc_valid <= 1'b0;
      end else begin
         de_first  <= dly_p[3];
         de_last   <= dly_p[4];
         crc_valid <= de && de_last;
         if (de) crc_acc <= crc_nxt;
         if (de && de_last) crc <= crc_nxt;
      end
   end
`endif
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two small timing modes checked every cycle against an arithmetic raster model.
module tb_vga_scanout;
   typedef struct packed {
      int hv, hf, hs, hb, vv, vf, vs, vb, lat;
      bit hpol, vpol;
      int src_id;
   } mode_t;

   typedef struct packed {
      int x, y, fr;
      bit rv, fs, hs, vs, de, first, last;
      logic [11:0] rgb;
   } exp_t;

   // A: 8/1/2/1 x 4/1/1/1, hsync active-high, latency 2, source returns coordinates
   // B: 16-clock lines (XW exactly 4), vsync window ending at V_TOTAL, latency 0, source all-ones
   localparam mode_t MA = '{8, 1, 2, 1, 4, 1, 1, 1, 2, 1'b1, 1'b0, 0};
   localparam mode_t MB = '{10, 2, 3, 1, 3, 1, 2, 0, 0, 1'b0, 1'b1, 1};
   localparam int A_XW = $clog2(12);
   localparam int A_YW = $clog2(7);
   localparam int B_XW = $clog2(16);
   localparam int B_YW = $clog2(6);

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   tcur   = 0;

   vga_scanout_if #(.XW(A_XW), .YW(A_YW), .COLOR_W(4)) ia ();
   vga_scanout_if #(.XW(B_XW), .YW(B_YW), .COLOR_W(4)) ib ();

   logic       a_hs, a_vs, a_de, b_hs, b_vs, b_de;
   logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
`ifdef VGA_SCANOUT_CRC_EN
   logic [15:0] a_crc, b_crc;
   logic        a_cv, b_cv;
   logic [15:0] cacc [2];
   logic [15:0] chold [2];
`endif

   vga_scanout #(
      .H_VISIBLE(MA.hv), .H_FRONT(MA.hf), .H_SYNC(MA.hs), .H_BACK(MA.hb),
      .V_VISIBLE(MA.vv), .V_FRONT(MA.vf), .V_SYNC(MA.vs), .V_BACK(MA.vb),
      .HSYNC_POL(MA.hpol), .VSYNC_POL(MA.vpol), .COLOR_W(4), .SRC_LATENCY(MA.lat)
   ) dut_a (
      .clk_25_175(clk), .rst(rst), .src_if(ia.master),
      .hsync(a_hs), .vsync(a_vs), .de(a_de), .r(a_r), .g(a_g), .b(a_b)
`ifdef VGA_SCANOUT_CRC_EN
      , .crc(a_crc), .crc_valid(a_cv)
`endif
   );

   vga_scanout #(
      .H_VISIBLE(MB.hv), .H_FRONT(MB.hf), .H_SYNC(MB.hs), .H_BACK(MB.hb),
      .V_VISIBLE(MB.vv), .V_FRONT(MB.vf), .V_SYNC(MB.vs), .V_BACK(MB.vb),
      .HSYNC_POL(MB.hpol), .VSYNC_POL(MB.vpol), .COLOR_W(4), .SRC_LATENCY(MB.lat)
   ) dut_b (
      .clk_25_175(clk), .rst(rst), .src_if(ib.master),
      .hsync(b_hs), .vsync(b_vs), .de(b_de), .r(b_r), .g(b_g), .b(b_b)
`ifdef VGA_SCANOUT_CRC_EN
      , .crc(b_crc), .crc_valid(b_cv)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %0h want %0h", nm, tcur, act, exp);
      end
   endtask

   function automatic logic [11:0] src_val(int id, int x, int y);
      if (id == 1) return 12'hFFF;
      return {4'(x), 4'(y), 4'(x + y)};
   endfunction

   // Counter state s = t cycles after release; pins show state t-lat-1; src carries state t-lat
   function automatic exp_t model(mode_t m, int t);
      exp_t e;
      int ht, vt, s, h, v;
      ht = m.hv + m.hf + m.hs + m.hb;
      vt = m.vv + m.vf + m.vs + m.vb;
      e = '0;
      e.x  = t % ht;
      e.y  = (t / ht) % vt;
      e.fr = t / (ht * vt);
      e.rv = (e.x < m.hv) && (e.y < m.vv);
      e.fs = (e.x == 0) && (e.y == 0);
      e.hs = !m.hpol;
      e.vs = !m.vpol;
      s = t - m.lat - 1;
      if (s >= 0) begin
         h = s % ht;
         v = (s / ht) % vt;
         e.de = (h < m.hv) && (v < m.vv);
         if (h >= m.hv + m.hf && h < m.hv + m.hf + m.hs) e.hs = m.hpol;
         if (v >= m.vv + m.vf && v < m.vv + m.vf + m.vs) e.vs = m.vpol;
         if (e.de) e.rgb = src_val(m.src_id, h, v);
         e.first = e.de && h == 0 && v == 0;
         e.last  = e.de && h == m.hv - 1 && v == m.vv - 1;
      end
      return e;
   endfunction

   function automatic logic [11:0] src_at(mode_t m, int t);
      int ht, vt, s;
      ht = m.hv + m.hf + m.hs + m.hb;
      vt = m.vv + m.vf + m.vs + m.vb;
      s = t - m.lat;
      if (s < 0) return 12'hEEE;
      return src_val(m.src_id, s % ht, (s / ht) % vt);
   endfunction

   task automatic cmp_dut(string tg, exp_t e, logic [31:0] rx, logic [31:0] ry, logic rv, logic fs,
                          logic [31:0] fr, logic hs, logic vs, logic dv, logic [11:0] rgb);
      chk({tg, "_req_x"}, rx, 32'(e.x));
      chk({tg, "_req_y"}, ry, 32'(e.y));
      chk({tg, "_req_valid"}, 32'(rv), 32'(e.rv));
      chk({tg, "_frame_start"}, 32'(fs), 32'(e.fs));
      chk({tg, "_frame"}, fr, 32'(e.fr));
      chk({tg, "_hsync"}, 32'(hs), 32'(e.hs));
      chk({tg, "_vsync"}, 32'(vs), 32'(e.vs));
      chk({tg, "_de"}, 32'(dv), 32'(e.de));
      chk({tg, "_rgb"}, 32'(rgb), 32'(e.rgb));
   endtask

`ifdef VGA_SCANOUT_CRC_EN
   function automatic logic [15:0] crc_fold(logic [15:0] c_in, logic [11:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   task automatic crc_step(int k, string tg, mode_t m, int t, logic [15:0] c, logic cv);
      exp_t e, ep;
      logic cv_exp;
      cv_exp = 1'b0;
      if (t > 0) begin
         ep = model(m, t - 1);
         cv_exp = ep.last;
      end
      chk({tg, "_crc"}, 32'(c), 32'(chold[k]));
      chk({tg, "_crc_valid"}, 32'(cv), 32'(cv_exp));
      e = model(m, t);
      if (e.de) cacc[k] = crc_fold(e.first ? 16'hFFFF : cacc[k], e.rgb);
      if (e.last) chold[k] = cacc[k];
   endtask
`endif

   task automatic check_reset(string tg);
      chk({tg, "_a_req_xy"}, 32'({ia.req_x, ia.req_y}), 32'd0);
      chk({tg, "_a_frame"}, ia.frame, 32'd0);
      chk({tg, "_a_frame_start"}, 32'(ia.frame_start), 32'd1);
      chk({tg, "_a_pins"}, 32'({a_hs, a_vs, a_de, a_r, a_g, a_b}), 32'({!MA.hpol, !MA.vpol, 13'd0}));
      chk({tg, "_b_req_xy"}, 32'({ib.req_x, ib.req_y}), 32'd0);
      chk({tg, "_b_frame"}, ib.frame, 32'd0);
      chk({tg, "_b_pins"}, 32'({b_hs, b_vs, b_de, b_r, b_g, b_b}), 32'({!MB.hpol, !MB.vpol, 13'd0}));
`ifdef VGA_SCANOUT_CRC_EN
      chk({tg, "_crc_reset"}, 32'({a_crc, b_crc, a_cv, b_cv}), 32'd0);
      chold[0] = '0;
      chold[1] = '0;
      cacc[0]  = '0;
      cacc[1]  = '0;
`endif
   endtask

   int a_hs_hi, a_vs_lo, a_de_hi, a_fs_cnt, b_hs_lo, b_vs_hi, b_de_hi, b_fs_cnt;

   task automatic run_phase(int n, bit tally);
      exp_t ea, eb;
      for (int t = 0; t < n; t++) begin
         tcur = t;
         {ia.src_r, ia.src_g, ia.src_b} = src_at(MA, t);
         {ib.src_r, ib.src_g, ib.src_b} = src_at(MB, t);
         #1;
         ea = model(MA, t);
         eb = model(MB, t);
         cmp_dut("a", ea, 32'(ia.req_x), 32'(ia.req_y), ia.req_valid, ia.frame_start, ia.frame,
                 a_hs, a_vs, a_de, {a_r, a_g, a_b});
         cmp_dut("b", eb, 32'(ib.req_x), 32'(ib.req_y), ib.req_valid, ib.frame_start, ib.frame,
                 b_hs, b_vs, b_de, {b_r, b_g, b_b});
`ifdef VGA_SCANOUT_CRC_EN
         crc_step(0, "a", MA, t, a_crc, a_cv);
         crc_step(1, "b", MB, t, b_crc, b_cv);
`endif
         if (tally) begin
            if (t >= 3 && t < 87) begin
               a_hs_hi  += int'(a_hs);
               a_vs_lo  += int'(!a_vs);
               a_de_hi  += int'(a_de);
               a_fs_cnt += int'(ia.frame_start);
            end
            if (t >= 1 && t < 97) begin
               b_hs_lo  += int'(!b_hs);
               b_vs_hi  += int'(b_vs);
               b_de_hi  += int'(b_de);
               b_fs_cnt += int'(ib.frame_start);
            end
            if (t == 3)  chk("lit_a_first_pixel", 32'({a_de, a_r}), 32'({1'b1, 4'd0}));
            if (t == 10) chk("lit_a_last_pixel", 32'({a_de, a_r}), 32'({1'b1, 4'd15 & 4'd7}));
            if (t == 11) chk("lit_a_blank", 32'({a_de, a_r, a_g, a_b}), 32'd0);
            if (t == 83) chk("lit_a_frame83", ia.frame, 32'd0);
            if (t == 84) chk("lit_a_frame84", ia.frame, 32'd1);
            if (t == 1)  chk("lit_b_first_pixel", 32'({b_de, b_r, b_g, b_b}), 32'h1FFF);
            if (t == 11) chk("lit_b_blank", 32'({b_de, b_r, b_g, b_b}), 32'd0);
            if (t == 96) chk("lit_b_frame96", ib.frame, 32'd1);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      a_hs_hi = 0; a_vs_lo = 0; a_de_hi = 0; a_fs_cnt = 0;
      b_hs_lo = 0; b_vs_hi = 0; b_de_hi = 0; b_fs_cnt = 0;
      rst = 1'b0;
      {ia.src_r, ia.src_g, ia.src_b} = 12'hEEE;
      {ib.src_r, ib.src_g, ib.src_b} = 12'hFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset("init");
      @(negedge clk);
      rst = 1'b1;
      run_phase(200, 1'b1);

      chk("cnt_a_hsync_high", 32'(a_hs_hi), 32'd14);
      chk("cnt_a_vsync_low", 32'(a_vs_lo), 32'd12);
      chk("cnt_a_de", 32'(a_de_hi), 32'd32);
      chk("cnt_a_frame_start", 32'(a_fs_cnt), 32'd1);
      chk("cnt_b_hsync_low", 32'(b_hs_lo), 32'd18);
      chk("cnt_b_vsync_high", 32'(b_vs_hi), 32'd32);
      chk("cnt_b_de", 32'(b_de_hi), 32'd30);
      chk("cnt_b_frame_start", 32'(b_fs_cnt), 32'd1);

      // asynchronous reset in the middle of a frame, away from any clock edge
      #3;
      rst = 1'b0;
      #1;
      tcur = -1;
      check_reset("midrst");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_phase(400, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
